toast_wb_arbiter: RTL

//  Owns the single regfile write port. Arbitrates between in-order pipeline writeback (P) and a non-pipelined

---
 rtl/toast_wb_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/toast_wb_arbiter.sv
// toast_wb_arbiter: shares the regfile write port between pipeline writeback and the multi-cycle unit, with a pending-register scoreboard
module toast_wb_arbiter #(
    parameter int REG_DATA_WIDTH     = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int REGFILE_DEPTH      = 32,
    parameter int STARVE_LIMIT       = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          p_valid_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] p_rd_addr_i,
    input  logic [REG_DATA_WIDTH-1:0]     p_rd_data_i,
    output logic                          p_stall_o,
    input  logic                          m_valid_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] m_rd_addr_i,
    input  logic [REG_DATA_WIDTH-1:0]     m_rd_data_i,
    output logic                          m_ready_o,
    input  logic                          issue_valid_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] issue_rd_addr_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] rs2_addr_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] rd_chk_addr_i,
    output logic                          hazard_o,
    output logic [REGFILE_ADDR_WIDTH-1:0] rd_addr_o,
    output logic [REG_DATA_WIDTH-1:0]     rd_wr_data_o,
    output logic                          rd_wr_en_o
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic {PIPE_PRI, M_PRI} pri_t;
    pri_t                     pri_q, pri_d;
    logic [CW-1:0]            wait_q, wait_d;
    logic [REGFILE_DEPTH-1:0] pending_q, pending_d, set_vec, clr_vec, live;
    logic                     p_grant, m_hs;

    assign m_hs = m_valid_i & m_ready_o;

    // Grant selection and starvation counter; M is refused only while P holds priority
    always_comb begin
        pri_d     = pri_q;
        wait_d    = wait_q;
        m_ready_o = 1'b0;
        p_stall_o = 1'b0;
        p_grant   = 1'b0;
        if (!reset_i) begin
            if (pri_q == PIPE_PRI) begin
                p_grant   = p_valid_i;
                m_ready_o = m_valid_i & ~p_valid_i;
                if (m_valid_i && p_valid_i) begin
                    wait_d = wait_q + CW'(1);
                    if (wait_d >= CW'(STARVE_LIMIT)) pri_d = M_PRI;
                end
            end else begin
                m_ready_o = m_valid_i;
                p_stall_o = p_valid_i;
            end
            if (m_valid_i && m_ready_o) begin
                wait_d = '0;
                pri_d  = PIPE_PRI;
            end
        end
    end

    assign rd_addr_o    = p_grant ? p_rd_addr_i : m_hs ? m_rd_addr_i : '0;
    assign rd_wr_data_o = p_grant ? p_rd_data_i : m_hs ? m_rd_data_i : '0;
    assign rd_wr_en_o   = (p_grant | m_hs) & (rd_addr_o != '0);

    // Scoreboard update; a same-cycle set of the register being cleared wins
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid_i && issue_rd_addr_i != '0) set_vec[issue_rd_addr_i] = 1'b1;
        if (m_hs) clr_vec[m_rd_addr_i] = 1'b1;
    end

    assign live      = pending_q & ~clr_vec;
    assign pending_d = live | set_vec;
    assign hazard_o  = ~reset_i & (((rs1_addr_i != '0) & live[rs1_addr_i]) |
                                   ((rs2_addr_i != '0) & live[rs2_addr_i]) |
                                   ((rd_chk_addr_i != '0) & live[rd_chk_addr_i]));

    // State registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pri_q     <= PIPE_PRI;
            wait_q    <= '0;
            pending_q <= '0;
        end else begin
            pri_q     <= pri_d;
            wait_q    <= wait_d;
            pending_q <= pending_d;
        end
    end

    // M is non-pipelined: a new issue must not overlap an unfinished tracked op
    always_ff @(posedge clk_i) begin
        if (!reset_i && issue_valid_i && !m_hs)
            assert (pending_q == '0) else $error("second issue to M before handshake");
    end
endmodule
